// File: rtl/instruction_fetch.sv
// Fetch front end for the RV32E core.
// Drives the program ROM address, captures the returned word and buffers
// {pc, word} pairs in a small FIFO. The decoder drains the FIFO through a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr_bus,
  input  logic [31:0] data_bus,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [31:0]      RESET_FETCH = {RESET_PC[31:2], 2'b00};

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] mem_pc   [FIFO_DEPTH];
  logic [31:0] mem_word [FIFO_DEPTH];

  logic pop_req;
  logic pop;
  logic push;

  // Handshake decode; a redirect cancels both the pop and the write.
  always_comb begin
    pop_req = instr_valid && instr_ready;
    pop     = pop_req && !redirect_valid;
    push    = !redirect_valid && ((count != FULL_CNT) || pop_req);
  end

  // Fetch PC, FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_FETCH;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_word[wr_ptr] <= data_bus;
    end
  end

  // ROM address comes straight from the register.
  always_comb begin
    addr_bus = fetch_pc;
  end

  // Head presentation to the decoder, NOP and pc 0 while empty.
  always_comb begin
    instr_valid = (count != '0);
    instr       = NOP_WORD;
    instr_pc    = '0;
    if (instr_valid) begin
      instr    = mem_word[rd_ptr];
      instr_pc = mem_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized
// run against a queue-based reference model of the prefetch buffer.
module tb_instruction_fetch;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_bus;
  logic [31:0] data_bus;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        rst2 = 1'b0;
  logic [31:0] addr_bus2;
  logic [31:0] data_bus2;
  logic        instr_valid2;
  logic        instr_ready2 = 1'b0;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] q_pc[$];
  logic [31:0] q_word[$];

  always #5 clk = ~clk;

  // Program ROM: ORI x1,x0,3 at 0, SLTI words elsewhere tagged by address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h0030_6093;
    return {a[13:2] ^ a[31:20], 5'd0, 3'b010, 5'd1, 7'h13};
  endfunction

  assign data_bus  = rom(addr_bus);
  assign data_bus2 = rom(addr_bus2);

  instruction_fetch dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(4), .NOP_WORD(NOP)) dut2 (
    .clk(clk), .rst(rst2), .addr_bus(addr_bus2), .data_bus(data_bus2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .instr(instr2), .instr_pc(instr_pc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = {rpc[31:2], 2'b00};
    q_pc.delete();
    q_word.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit pop;
    bit wr;
    if (redirect_valid) begin
      q_pc.delete();
      q_word.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      pop = (q_pc.size() != 0) && instr_ready;
      wr  = (q_pc.size() < DEPTH) || pop;
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_word.pop_front());
      end
      if (wr) begin
        q_pc.push_back(m_pc);
        q_word.push_back(rom(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    #1 rst = 1'b1;
    rst2 = 1'b1;
    #2;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr, NOP); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", instr_pc); end
    checks++; if (addr_bus !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", addr_bus); end
    checks++; if (addr_bus2 !== WRAP_PC) begin errors++; $display("FAIL reset_addr2 got %h want %h", addr_bus2, WRAP_PC); end
    repeat (2) tick();
    rst2 = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, instr_valid); end
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, exp_pc); end
      if (i == 0) begin
        checks++; if (instr !== 32'h0030_6093) begin errors++; $display("FAIL stream_first_word got %h want 00306093", instr); end
      end else begin
        checks++; if (instr !== rom(exp_pc)) begin errors++; $display("FAIL stream_word[%0d] got %h want %h", i, instr, rom(exp_pc)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    instr_ready = 1'b0;
    pulse_reset();
    repeat (5) tick();
    checks++; if (addr_bus !== 32'h8) begin errors++; $display("FAIL stall_addr got %h want 8", addr_bus); end
    checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_head got pc=%h v=%0b want pc=0 v=1", instr_pc, instr_valid); end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin errors++; $display("FAIL stall_drain[%0d] got pc=%h v=%0b want pc=%h v=1", k, instr_pc, instr_valid, exp_pc); end
      checks++; if (instr !== rom(exp_pc)) begin errors++; $display("FAIL stall_word[%0d] got %h want %h", k, instr, rom(exp_pc)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0;
    pulse_reset();
    repeat (3) tick();
    instr_ready = 1'b1;
    // Full FIFO with a pop pending: redirect wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL redir_instr got %h want %h", instr, NOP); end
    checks++; if (addr_bus !== 32'h40) begin errors++; $display("FAIL redir_addr got %h want 40", addr_bus); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin errors++; $display("FAIL redir_first got pc=%h v=%0b want pc=40 v=1", instr_pc, instr_valid); end
    // Misaligned target is truncated.
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    checks++; if (addr_bus !== 32'h40) begin errors++; $display("FAIL misalign_addr got %h want 40", addr_bus); end
    tick();
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL misalign_pc got %h want 40", instr_pc); end
    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || addr_bus !== 32'h200) begin errors++; $display("FAIL b2b_bubble got v=%0b addr=%h want v=0 addr=200", instr_valid, addr_bus); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("FAIL b2b_first got pc=%h v=%0b want pc=200 v=1", instr_pc, instr_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    instr_ready2 = 1'b1;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = WRAP_PC + 32'(4 * i);
      checks++; if (instr_valid2 !== 1'b1 || instr_pc2 !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d] got pc=%h v=%0b want pc=%h v=1", i, instr_pc2, instr_valid2, exp_pc); end
      checks++; if (instr2 !== rom(exp_pc)) begin errors++; $display("FAIL wrap_word[%0d] got %h want %h", i, instr2, rom(exp_pc)); end
    end
    // Depth-4 stall: four fetches, address wraps past zero to 8.
    instr_ready2 = 1'b0;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    repeat (6) tick();
    checks++; if (addr_bus2 !== 32'h8) begin errors++; $display("FAIL wrap_stall_addr got %h want 8", addr_bus2); end
    checks++; if (instr_pc2 !== WRAP_PC) begin errors++; $display("FAIL wrap_stall_head got %h want %h", instr_pc2, WRAP_PC); end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    pulse_reset();
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0b want 0", instr_valid); end
    checks++; if (addr_bus !== 32'h0) begin errors++; $display("FAIL async_addr got %h want 0", addr_bus); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL async_restart got pc=%h v=%0b want pc=0 v=1", instr_pc, instr_valid); end
    checks++; if (addr_bus !== 32'h4) begin errors++; $display("FAIL async_next_addr got %h want 4", addr_bus); end
  endtask

  task automatic test_random();
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    rst = 1'b1;
    tick();
    model_reset(32'h0);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      exp_valid = (q_pc.size() != 0);
      exp_instr = exp_valid ? q_word[0] : NOP;
      exp_pc    = exp_valid ? q_pc[0] : 32'h0;
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c%0d got %0b want %0b", c, instr_valid, exp_valid); end
      checks++; if (instr !== exp_instr) begin errors++; $display("FAIL rand_instr c%0d got %h want %h", c, instr, exp_instr); end
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL rand_pc c%0d got %h want %h", c, instr_pc, exp_pc); end
      checks++; if (addr_bus !== m_pc) begin errors++; $display("FAIL rand_addr c%0d got %h want %h", c, addr_bus, m_pc); end
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = {20'h0, 12'($urandom)};
      model_step();
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front end of the RV32E core: the reader side of the program ROM interface. It drives the byte address on `addr_bus`, captures the word returned combinationally on `data_bus`, and buffers fetched instructions with their PCs in a small FIFO. The FIFO feeds the decoder through a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded at reset.
- `FIFO_DEPTH`, default 2: prefetch entries; power of two, at least 2.
- `NOP_WORD`, default 32'h0000_0013: value on `instr` while empty (ADDI x0,x0,0).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr_bus`  out  32  byte address to the program ROM; always word-aligned.
- `data_bus`  in  32  instruction word from the ROM; combinational, valid in the same cycle as `addr_bus`.
- `redirect_valid`  in  1  one-cycle pulse requesting a PC change.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored.
- `instr_valid`  out  1  the FIFO head holds an instruction.
- `instr_ready`  in  1  the decoder accepts the head this cycle.
- `instr`  out  32  head instruction word, or `NOP_WORD` when empty.
- `instr_pc`  out  32  byte address of the head instruction; 0 when empty.

## Operation
- State:
  - `fetch_pc` register (32 bits).
  - FIFO of {pc, word} entries with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
- `addr_bus` = `fetch_pc`, driven straight from the register with no combinational path from any input.
- Pop: `instr_valid && instr_ready` removes the head.
- Write enable: count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop in the same cycle.
- On a write, {`fetch_pc`, `data_bus`} is pushed and `fetch_pc` advances by 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- No write: `fetch_pc` holds and `addr_bus` stays stable.
- Redirect has highest priority. When `redirect_valid` = 1:
  - count goes to 0 and both pointers reset to 0;
  - any pop or write in that cycle is discarded;
  - `fetch_pc` loads {`redirect_pc`[31:2], 2'b00}.
- Pointers wrap modulo FIFO_DEPTH.
- Entries leave in fetch order, with none dropped and none duplicated.
- `instr_valid` = (count != 0). `instr` and `instr_pc` come from the head entry, or `NOP_WORD` and 0 when empty.
- Reset, asynchronous and effective immediately even mid-operation:
  - `fetch_pc` = `RESET_PC` with bits [1:0] forced to 0;
  - count = 0 and both pointers = 0;
  - `instr_valid` = 0, `instr` = `NOP_WORD`, `instr_pc` = 0, `addr_bus` = `RESET_PC`.

## Timing
- Fetch-to-issue latency: 1 cycle. The word addressed in cycle N is on `instr` in cycle N+1 if the FIFO was empty.
- Steady state with `instr_ready` held high: one instruction per cycle, and `instr_pc` increments by 4 each cycle.
- Redirect in cycle N:
  - cycle N+1: `instr_valid` = 0 and `addr_bus` = the redirect target;
  - cycle N+2: the first target instruction is valid.
  - Two-cycle bubble in total.
- Decoder stall, `instr_ready` low:
  - the FIFO fills within FIFO_DEPTH cycles, then fetch stops;
  - the head stays stable until accepted;
  - the handshake obeys standard valid/ready rules: `instr_valid` does not drop without a pop or a redirect.
- Full FIFO plus a pop in the same cycle: one entry is popped and one written, so count is unchanged and fetch continues at full rate.
- Redirect while empty, or together with `instr_ready`: the redirect wins, nothing is consumed and nothing is written.
- Back-to-back redirects: the last one wins, and the bubble restarts from the last redirect.

## Test plan
1. ROM holds ORI x1,x0,3 at 0 and SLTI words at 4..20; release reset with `instr_ready` = 1.
   -> Cycle 1: `instr_pc` = 0 and `instr` = 32'h0030_6093.
   -> Then PCs 4, 8, 12, 16, 20 on consecutive cycles.
2. Hold `instr_ready` = 0 for 5 cycles from reset.
   -> count saturates at 2 and `addr_bus` holds 8.
   -> After release, PCs 0, 4, 8, 12 are issued in order with no gaps after the first.
3. FIFO full and `instr_ready` = 1; pulse `redirect_valid` with `redirect_pc` = 32'h40.
   -> Next cycle: `instr_valid` = 0, `instr` = 32'h0000_0013, `addr_bus` = 32'h40.
   -> Following cycle: `instr_pc` = 32'h40.
4. `redirect_pc` = 32'h43.
   -> `addr_bus` = 32'h40 and the first issued `instr_pc` = 32'h40.
5. `RESET_PC` = 32'hFFFF_FFF8 with `instr_ready` = 1.
   -> Issued PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
6. Assert `rst` between clock edges while instructions are streaming.
   -> `instr_valid` = 0 and `addr_bus` = `RESET_PC` before the next edge.
   -> After release, fetch restarts at `RESET_PC`.
